// File: rtl/bus_pkg.sv
// Shared bus widths for the leader-to-system-bus arbiter.
// Pure constants; no logic, no latency, no flow control.
package bus_pkg;
    localparam int AddrWidth       = 32;
    localparam int DataWidth       = 32;
    localparam int ByteEnableWidth = 4;
endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin pick among requests, starting one past ptr_i; purely combinational.
// Zero latency; no backpressure of its own, callers mask ineligible requests.
module round_robin_arbiter
    import bus_pkg::*;
#(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);
    logic [IdxW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // Offset N wraps back to ptr_i itself, so the last winner is tried last.
        for (int k = 1; k <= N; k++) begin
            cand = IdxW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter from N leaders to one system bus; bus request 1 cycle after grant, read data routed same cycle.
// Backpressure: leader_ready withheld for reads while the in-order outstanding-read queue is full; writes always eligible.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int Leaders         = 2,
    parameter int OutstandingBits = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [Leaders-1:0]                   leader_read_req,
    input  logic [Leaders-1:0]                   leader_write_req,
    input  logic [Leaders*AddrWidth-1:0]         leader_addr,
    input  logic [Leaders*DataWidth-1:0]         leader_write_data,
    input  logic [Leaders*ByteEnableWidth-1:0]   leader_byte_enable,
    output logic [Leaders-1:0]                   leader_ready,
    output logic [DataWidth-1:0]                 leader_read_data,
    output logic [Leaders-1:0]                   leader_read_data_valid,
    output logic [AddrWidth-1:0]                 bus_addr,
    output logic [DataWidth-1:0]                 bus_write_data,
    output logic [ByteEnableWidth-1:0]           bus_byte_enable,
    output logic                                 bus_read_req,
    output logic                                 bus_write_req,
    input  logic [DataWidth-1:0]                 bus_read_data,
    input  logic                                 bus_read_data_valid,
    output logic                                 orphan_response
);
    localparam int Depth = 1 << OutstandingBits;
    localparam int IdxW  = (Leaders > 1) ? $clog2(Leaders) : 1;

    logic [IdxW-1:0]            last_q;
    logic [IdxW-1:0]            fifo_q [Depth];
    logic [OutstandingBits-1:0] head_q, tail_q;
    logic [OutstandingBits:0]   count_q, count_d;
    logic                       orphan_q;

    logic [AddrWidth-1:0]       bus_addr_q, bus_addr_d;
    logic [DataWidth-1:0]       bus_wdat_q, bus_wdat_d;
    logic [ByteEnableWidth-1:0] bus_be_q, bus_be_d;
    logic                       bus_rd_q, bus_rd_d;
    logic                       bus_wr_q, bus_wr_d;

    logic                       full;
    logic [Leaders-1:0]         eligible, gnt;
    logic [IdxW-1:0]            gnt_idx;
    logic                       gnt_vld, accept, is_write, push, pop;

    // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
    assign full     = (count_q == (OutstandingBits + 1)'(Depth));
    assign eligible = leader_write_req | (leader_read_req & {Leaders{~full}});

    round_robin_arbiter #(.N(Leaders), .IdxW(IdxW)) u_rr (
        .req_i   (eligible),
        .ptr_i   (last_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    assign accept       = gnt_vld & ~reset;
    assign leader_ready = accept ? gnt : '0;
    assign is_write     = |(gnt & leader_write_req);
    assign push         = accept & ~is_write;
    assign pop          = bus_read_data_valid & (count_q != '0) & ~reset;
    assign count_d      = count_q + (OutstandingBits + 1)'(push) - (OutstandingBits + 1)'(pop);

    always_comb begin
        bus_addr_d = '0;
        bus_wdat_d = '0;
        bus_be_d   = '0;
        bus_rd_d   = 1'b0;
        bus_wr_d   = 1'b0;
        for (int i = 0; i < Leaders; i++) begin
            if (accept && gnt[i]) begin
                bus_addr_d = leader_addr[i*AddrWidth +: AddrWidth];
                bus_wdat_d = leader_write_data[i*DataWidth +: DataWidth];
                bus_be_d   = leader_byte_enable[i*ByteEnableWidth +: ByteEnableWidth];
                bus_rd_d   = ~is_write;
                bus_wr_d   = is_write;
            end
        end
    end

    always_comb begin
        leader_read_data_valid = '0;
        for (int i = 0; i < Leaders; i++) begin
            if (pop && fifo_q[head_q] == IdxW'(i)) leader_read_data_valid[i] = 1'b1;
        end
    end
    assign leader_read_data = pop ? bus_read_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= IdxW'(Leaders - 1);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            orphan_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_wdat_q <= '0;
            bus_be_q   <= '0;
            bus_rd_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
        end else begin
            if (accept) last_q <= gnt_idx;
            if (push) begin
                fifo_q[tail_q] <= gnt_idx;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            count_q <= count_d;
            if (bus_read_data_valid && count_q == '0) orphan_q <= 1'b1;
            bus_addr_q <= bus_addr_d;
            bus_wdat_q <= bus_wdat_d;
            bus_be_q   <= bus_be_d;
            bus_rd_q   <= bus_rd_d;
            bus_wr_q   <= bus_wr_d;
        end
    end

    assign bus_addr        = bus_addr_q;
    assign bus_write_data  = bus_wdat_q;
    assign bus_byte_enable = bus_be_q;
    assign bus_read_req    = bus_rd_q;
    assign bus_write_req   = bus_wr_q;
    assign orphan_response = orphan_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_bus_arbiter;
    localparam int N     = 2;
    localparam int OB    = 3;
    localparam int DEPTH = 1 << OB;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      rd_req, wr_req;
    logic [N*32-1:0]   addr, wdata;
    logic [N*4-1:0]    be;
    logic [N-1:0]      leader_ready, leader_read_data_valid;
    logic [31:0]       leader_read_data;
    logic [31:0]       bus_addr, bus_write_data, bus_read_data;
    logic [3:0]        bus_byte_enable;
    logic              bus_read_req, bus_write_req, bus_read_data_valid, orphan_response;

    bus_arbiter #(.Leaders(N), .OutstandingBits(OB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .leader_read_req        (rd_req),
        .leader_write_req       (wr_req),
        .leader_addr            (addr),
        .leader_write_data      (wdata),
        .leader_byte_enable     (be),
        .leader_ready           (leader_ready),
        .leader_read_data       (leader_read_data),
        .leader_read_data_valid (leader_read_data_valid),
        .bus_addr               (bus_addr),
        .bus_write_data         (bus_write_data),
        .bus_byte_enable        (bus_byte_enable),
        .bus_read_req           (bus_read_req),
        .bus_write_req          (bus_write_req),
        .bus_read_data          (bus_read_data),
        .bus_read_data_valid    (bus_read_data_valid),
        .orphan_response        (orphan_response)
    );

    always #5 clk = ~clk;

    // Pending leader requests (held until ready)
    bit          p_vld [N];
    bit          p_rd  [N];
    bit          p_wr  [N];
    logic [31:0] p_addr[N];
    logic [31:0] p_dat [N];
    logic [3:0]  p_be  [N];

    // Reference model state
    int          m_last;
    int          m_q[$];
    bit          m_orphan;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    bit          e_rd, e_wr;

    bit          rsp_vld;
    logic [31:0] rsp_dat;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic new_req(input int i, input int kind, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        p_vld[i]  = 1'b1;
        p_rd[i]   = (kind != 1);
        p_wr[i]   = (kind != 0);
        p_addr[i] = a;
        p_dat[i]  = d;
        p_be[i]   = b;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last   = N - 1;
        m_orphan = 1'b0;
        e_addr = '0; e_wdata = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) p_vld[i] = 1'b0;
        rd_req = '0; wr_req = '0; addr = '0; wdata = '0; be = '0;
        bus_read_data_valid = 1'b0; bus_read_data = '0;
        rsp_vld = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: drive, check mid-cycle, then advance the model across the edge.
    task automatic step();
        int g;
        bit full;
        logic [31:0] exp_rdy, exp_val;
        for (int i = 0; i < N; i++) begin
            rd_req[i]        = p_vld[i] && p_rd[i];
            wr_req[i]        = p_vld[i] && p_wr[i];
            addr[i*32 +: 32] = p_addr[i];
            wdata[i*32 +: 32] = p_dat[i];
            be[i*4 +: 4]     = p_be[i];
        end
        bus_read_data_valid = rsp_vld;
        bus_read_data       = rsp_dat;
        #4;
        g    = -1;
        full = (m_q.size() >= DEPTH);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (g < 0 && p_vld[c] && (p_wr[c] || !full)) g = c;
        end
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        exp_val = (rsp_vld && m_q.size() > 0) ? (32'd1 << m_q[0]) : 32'd0;
        check("ready", 32'(leader_ready), exp_rdy);
        check("rd_valid", 32'(leader_read_data_valid), exp_val);
        if (exp_val != 0) check("rd_data", leader_read_data, rsp_dat);
        check("bus_addr", bus_addr, e_addr);
        check("bus_wdata", bus_write_data, e_wdata);
        check("bus_be", 32'(bus_byte_enable), 32'(e_be));
        check("bus_rd", 32'(bus_read_req), 32'(e_rd));
        check("bus_wr", 32'(bus_write_req), 32'(e_wr));
        check("orphan", 32'(orphan_response), 32'(m_orphan));
        @(posedge clk); #1;
        if (rsp_vld) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_orphan = 1'b1;
        end
        if (g >= 0) begin
            e_addr = p_addr[g]; e_wdata = p_dat[g]; e_be = p_be[g];
            e_wr = p_wr[g]; e_rd = !p_wr[g];
            if (!p_wr[g]) m_q.push_back(g);
            m_last   = g;
            p_vld[g] = 1'b0;
        end else begin
            e_addr = '0; e_wdata = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0;
        end
        rsp_vld = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            p_vld[i] = 1'b0; p_rd[i] = 1'b0; p_wr[i] = 1'b0;
            p_addr[i] = '0; p_dat[i] = '0; p_be[i] = '0;
        end
        rsp_dat = '0;
        do_reset();
        step();

        // Two leaders reading back to back: grants alternate 0,1,...
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++)
                if (!p_vld[i]) new_req(i, 0, $urandom, $urandom, 4'($urandom));
            step();
        end
        do_reset();

        // In-order responses routed to the right leaders.
        new_req(1, 0, 32'h100, 32'h0, 4'hF); step();
        new_req(0, 0, 32'h200, 32'h0, 4'hF); step();
        step();
        rsp_vld = 1'b1; rsp_dat = 32'hAAAA; step();
        rsp_vld = 1'b1; rsp_dat = 32'hBBBB; step();
        do_reset();

        // Fill the queue; 9th read waits one cycle past the freeing response.
        for (int c = 0; c < 12; c++) begin
            if (!p_vld[0]) new_req(0, 0, $urandom, $urandom, 4'($urandom));
            step();
        end
        rsp_vld = 1'b1; rsp_dat = $urandom; step();
        step();
        // Write while full is still granted.
        new_req(1, 1, 32'h300, 32'h12345678, 4'hF); step();
        new_req(0, 0, 32'h400, 32'h0, 4'h3); step();
        step();

        // Reset with reads outstanding: later response is an orphan, sticky until reset.
        do_reset();
        step();
        rsp_vld = 1'b1; rsp_dat = 32'hDEAD; step();
        step();
        step();
        do_reset();
        step();

        // Random traffic in phases of varying request/response pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int rq, rp;
            rq = 20 + 15 * ph;
            rp = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < N; i++)
                    if (!p_vld[i] && $urandom_range(99) < 32'(rq))
                        new_req(i, int'($urandom_range(2)), $urandom, $urandom, 4'($urandom));
                if (m_q.size() > 0 && $urandom_range(99) < 32'(rp)) begin
                    rsp_vld = 1'b1; rsp_dat = $urandom;
                end
                if ($urandom_range(399) == 0) do_reset();
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
